demux7_dist: RTL and testbench
==============================

// Module: demux7_dist
// PURPOSE
//   Inverse of the 7-way 32-bit datapath selector: accepts one word plus a 3-bit
//   destination code and delivers it into one of seven registered output slots.
//   Each slot is a one-entry buffer with a valid/ready handshake, so consumers can
//   drain independently. It sits between a producer stage (ALU/memory result) and
//   up to seven destination blocks (PC, HI/LO, register-file port, memory, etc.).
// PARAMETERS
//   WIDTH  32  data word width in bits
// PORTS
//   clk        in   1        system clock; all state on rising edge
//   reset_n    in   1        asynchronous, active-low reset
//   in_valid   in   1        producer has a word on in_data/in_sel
//   in_ready   out  1        block accepts the word this cycle (combinational)
//   in_sel     in   3        destination code 3'b000..3'b110; 3'b111 is illegal
//   in_data    in   WIDTH    word to deliver
//   out_valid  out  7        bit i: slot i holds an undelivered word
//   out_ready  in   7        bit i: consumer i takes slot i this cycle
//   out_data   out  7*WIDTH  slot i data at [i*WIDTH +: WIDTH]
//   err_drop   out  1        one-cycle pulse: an illegal-code word was dropped
//   drop_cnt   out  8        illegal-drop count (only with DEMUX7_DROPCNT_EN)
// BEHAVIOUR
//   Reset (async assert, sync-safe release): out_valid=0, out_data=0, err_drop=0,
//     drop_cnt=0. Reset mid-transfer discards every held word; nothing is replayed.
//   Accept: transfer occurs when in_valid && in_ready at the rising edge.
//   in_ready, for sel<7: !out_valid[sel] || out_ready[sel] (empty, or draining now).
//     For sel==7: in_ready=1 (illegal words are never stalled).
//     in_ready depends only on in_sel, out_valid and out_ready, never on in_valid.
//   Latency: an accepted word appears on slot sel with out_valid[sel]=1 on the next cycle.
//   Slot drain: out_valid[i] && out_ready[i] clears out_valid[i] at the edge, unless
//     the same edge loads slot i. Then out_valid[i] stays 1 with the new data
//     (back-to-back throughput of 1 word/cycle per slot).
//   Hold: while out_valid[i] && !out_ready[i], out_data slot i is stable.
//   Slots not addressed keep their state. Only one slot can be loaded per cycle.
//     Any number of slots can drain per cycle.
//   out_ready[i] while out_valid[i]=0: ignored, no effect.
//   Illegal code (sel==7, accepted): no slot changes; err_drop=1 for the next
//     cycle only. Consecutive illegal words give err_drop high on consecutive cycles.
//   out_data of an empty slot: holds its last value (don't-care for consumers).
//   No state machine beyond the per-slot valid bits. Registers: 7 x (1+WIDTH)
//     bits, plus err_drop and the optional counter.
// CONFIGURATION
//   DEMUX7_DROPCNT_EN defined: drop_cnt is an 8-bit counter. It increments on each
//     illegal-code acceptance and saturates at 8'hFF (no wrap). It clears only on reset.
//   DEMUX7_DROPCNT_EN undefined: drop_cnt is tied to 8'h00; no counter logic.
//   err_drop is present in both builds.
// TESTING
//   1. Reset, then send sel=3 data=32'hDEADBEEF with out_ready=0 -> next cycle
//      out_valid=7'b0001000, slot3=DEADBEEF, in_ready(sel=3)=0.
//   2. Slot 3 full, out_ready[3]=1, and a new word 32'h1 on sel=3 in the same cycle
//      -> accepted; out_valid[3] stays 1; slot3=32'h1 next cycle.
//   3. Stream sel=0..6 on 7 consecutive cycles with out_ready=0 -> out_valid=7'h7F;
//      each slot holds its own word; no slot overwritten.
//   4. Three consecutive sel=7 words -> in_ready=1 each cycle; no out_valid change;
//      err_drop high for 3 cycles; drop_cnt=3 (EN build) or 0 (non-EN build).
//   5. Slots 1 and 5 full; pull reset_n low mid-cycle -> out_valid=0 and out_data=0
//      immediately, without waiting for a clock edge.
//   6. 300 illegal words (EN build) -> drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/demux7_dist.sv
// demux7_dist: routes one WIDTH-bit word to one of seven one-entry output slots.
// Each slot is a registered buffer with its own valid/ready handshake. Code 7 is
// illegal: such words are accepted, dropped, and flagged on err_drop.
// Optional build macro DEMUX7_DROPCNT_EN adds a saturating 8-bit drop counter;
// without it drop_cnt is tied to zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// Ready never depends on the matching valid. A slot holds its data stable while
// valid is high and ready is low.
module demux7_dist #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [6:0]           out_valid,
    input  logic [6:0]           out_ready,
    output logic [7*WIDTH-1:0]   out_data,
    output logic                 err_drop,
    output logic [7:0]           drop_cnt
);

    localparam logic [2:0] SEL_ILLEGAL = 3'b111;

    // Per-code "can take a word now". Code 7 is always ready, so the top bit is 1.
    logic [7:0] room;
    logic       illegal;
    logic       accept;

    // Ready decode: a slot can take a word if it is empty or is draining this cycle.
    always_comb begin
        room     = {1'b1, (~out_valid) | out_ready};
        in_ready = room[in_sel];
        illegal  = (in_sel == SEL_ILLEGAL);
        accept   = in_valid && in_ready;
    end

    // Per-slot valid bit and data register. A load on the same edge as a drain wins,
    // which gives one word per cycle per slot.
    for (genvar g = 0; g < 7; g++) begin : g_slot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_valid[g]               <= 1'b0;
                out_data[g*WIDTH +: WIDTH] <= '0;
            end else if (accept && (in_sel == 3'(g))) begin
                out_valid[g]               <= 1'b1;
                out_data[g*WIDTH +: WIDTH] <= in_data;
            end else if (out_ready[g]) begin
                out_valid[g]               <= 1'b0;
            end
        end
    end

    // One-cycle pulse for each accepted illegal-code word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_drop <= 1'b0;
        end else begin
            err_drop <= accept && illegal;
        end
    end

`ifdef DEMUX7_DROPCNT_EN
    // Saturating count of dropped illegal-code words; cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'h00;
        end else if (accept && illegal && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_demux7_dist.sv
// Directed bench for demux7_dist: reset, single load, load-while-draining,
// full stream, illegal codes, async reset, counter saturation.
module tb_demux7_dist;

    localparam int W = 32;

    logic           clk;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [6:0]     out_valid;
    logic [6:0]     out_ready;
    logic [7*W-1:0] out_data;
    logic           err_drop;
    logic [7:0]     drop_cnt;

    int checks = 0;
    int errors = 0;

`ifdef DEMUX7_DROPCNT_EN
    localparam logic [7:0] CNT3   = 8'h03;
    localparam logic [7:0] CNTSAT = 8'hFF;
`else
    localparam logic [7:0] CNT3   = 8'h00;
    localparam logic [7:0] CNTSAT = 8'h00;
`endif

    demux7_dist #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_drop  (err_drop),
        .drop_cnt  (drop_cnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare an observed value with its expected value and count the result.
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] slot(input int i);
        return out_data[i*W +: W];
    endfunction

    // Directed stimulus sequence.
    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = '0;
        out_ready = 7'h00;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 7; i++) check($sformatf("rst_data%0d", i), slot(i), 32'h0);
        check("rst_err", 32'(err_drop), 32'h0);
        check("rst_cnt", 32'(drop_cnt), 32'h0);
        reset_n = 1'b1;
        step();

        // Single load to slot 3 with consumer stalled.
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF;
        #1 check("t1_ready_empty", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("t1_valid", 32'(out_valid), 32'h08);
        check("t1_slot3", slot(3), 32'hDEADBEEF);
        check("t1_ready_full", 32'(in_ready), 32'h0);
        in_valid = 1'b1; in_data = 32'h5555_5555;
        #1 check("t1_ready_no_valid_dep", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0;
        check("t1_hold", slot(3), 32'hDEADBEEF);

        // Load while draining the same slot.
        out_ready = 7'b0001000; in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h1;
        #1 check("t2_ready_drain", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0; out_ready = 7'h00;
        check("t2_valid", 32'(out_valid), 32'h08);
        check("t2_slot3", slot(3), 32'h1);
        out_ready = 7'b0001000;
        step();
        out_ready = 7'h00;
        check("t2_drained", 32'(out_valid), 32'h0);
        check("t2_data_kept", slot(3), 32'h1);

        // Stream to all seven slots, consumers stalled.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_data = 32'hA000_0000 + 32'(i);
            #1 check($sformatf("t3_ready%0d", i), 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 1'b0;
        check("t3_valid", 32'(out_valid), 32'h7F);
        for (int i = 0; i < 7; i++)
            check($sformatf("t3_slot%0d", i), slot(i), 32'hA000_0000 + 32'(i));
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hBAD0_0002;
        #1 check("t3_ready_full2", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0;
        check("t3_no_overwrite", slot(2), 32'hA000_0002);
        out_ready = 7'b1010101;
        step();
        check("t3_multi_drain", 32'(out_valid), 32'h2A);
        out_ready = 7'h7F;
        step();
        out_ready = 7'h00;
        check("t3_all_drained", 32'(out_valid), 32'h0);

        // Keep slot 6 occupied, then three illegal words.
        in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h6666_6666;
        step();
        in_sel = 3'd7; in_data = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4_ready%0d", i), 32'(in_ready), 32'h1);
            step();
            check($sformatf("t4_err%0d", i), 32'(err_drop), 32'h1);
            check($sformatf("t4_valid%0d", i), 32'(out_valid), 32'h40);
        end
        in_valid = 1'b0;
        step();
        check("t4_err_low", 32'(err_drop), 32'h0);
        check("t4_cnt", 32'(drop_cnt), 32'(CNT3));
        check("t4_slot6", slot(6), 32'h6666_6666);

        // Async reset with slots 1 and 5 full.
        in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h1111_1111;
        step();
        in_sel = 3'd5; in_data = 32'h5555_5555;
        step();
        in_valid = 1'b0;
        check("t5_pre_valid", 32'(out_valid), 32'h62);
        #3 reset_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_slot1", slot(1), 32'h0);
        check("t5_slot5", slot(5), 32'h0);
        check("t5_cnt", 32'(drop_cnt), 32'h0);
        #1 reset_n = 1'b1;
        step();
        check("t5_after", 32'(out_valid), 32'h0);

        // 300 illegal words: counter saturates.
        in_valid = 1'b1; in_sel = 3'd7; in_data = 32'h0;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        check("t6_err", 32'(err_drop), 32'h1);
        check("t6_cnt", 32'(drop_cnt), 32'(CNTSAT));
        check("t6_valid", 32'(out_valid), 32'h0);
        step();
        check("t6_err_low", 32'(err_drop), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
